// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
// ILLEGAL_TRAP_EN adds the HALT state for illegal-instruction trapping.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH
`ifdef ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
        logic [1:0] result_src;
    } ctrl_t;

    // Moore output table; architectural writes are qualified by the latched condition.
    function automatic ctrl_t ctrl_decode(input state_t s, input logic pass);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALU;
            end
            S_DECODE: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALU;
            end
            S_EXECR: begin
                c.alu_src_b = SRCB_REG;
                c.alu_op    = 1'b1;
            end
            S_EXECI: begin
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = 1'b1;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = pass;
            end
            S_MEMADR: c.alu_src_b = SRCB_IMM;
            S_MEMRD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_MEM;
                c.reg_write  = pass;
            end
            S_MEMWR: begin
                c.adr_src   = 1'b1;
                c.mem_write = pass;
            end
            S_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALU;
                c.pc_write   = pass;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cond_unit.sv
// Combinational condition-code evaluator against the registered {N,Z,C} flags.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [2:0] flags_i,
    output logic       pass_o
);

    logic n, z, c;
    assign {n, z, c} = flags_i;

    always_comb begin
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = ~z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = ~c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = ~n;
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor main control FSM with flag register and condition gating.
// Define ILLEGAL_TRAP_EN to trap op=11 into a sticky HALT state with a halted port.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] cond,
    input  logic       negative,
    input  logic       zero,
    input  logic       cout,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_op,
    output logic [1:0] result_src,
`ifdef ILLEGAL_TRAP_EN
    output logic       halted,
`endif
    output logic [2:0] flags
);

    state_t     state_q, state_d;
    logic       cond_pass_q, cond_pass_d;
    logic [2:0] flags_q, flags_d;
    ctrl_t      ctrl_q;
    logic       cond_ok;
    logic       unused_funct;

    assign unused_funct = ^funct[4:1];

    cond_unit u_cond (
        .cond_i  (cond),
        .flags_i (flags_q),
        .pass_o  (cond_ok)
    );

    always_comb begin
        state_d     = state_q;
        cond_pass_d = cond_pass_q;
        flags_d     = flags_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                cond_pass_d = cond_ok;
                case (op)
                    OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    default: state_d = S_HALT;
`else
                    default: state_d = S_FETCH;
`endif
                endcase
            end
            S_EXECR, S_EXECI: begin
                state_d = S_ALUWB;
                // Gated by the pre-update condition so a failed instruction leaves flags alone.
                if (funct[0] && cond_pass_q)
                    flags_d = {negative, zero, cout};
            end
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
`ifdef ILLEGAL_TRAP_EN
            S_HALT:   state_d = S_HALT;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            cond_pass_q <= 1'b0;
            flags_q     <= 3'b000;
            ctrl_q      <= ctrl_decode(S_FETCH, 1'b0);
        end else begin
            state_q     <= state_d;
            cond_pass_q <= cond_pass_d;
            flags_q     <= flags_d;
            ctrl_q      <= ctrl_decode(state_d, cond_pass_d);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic halted_q;
    always_ff @(posedge clk) begin
        if (!rst_n)
            halted_q <= 1'b0;
        else
            halted_q <= (state_d == S_HALT);
    end
    assign halted = halted_q;
`endif

    // Write enables are held off for the whole time reset is asserted.
    assign ir_write   = ctrl_q.ir_write  & rst_n;
    assign pc_write   = ctrl_q.pc_write  & rst_n;
    assign reg_write  = ctrl_q.reg_write & rst_n;
    assign mem_write  = ctrl_q.mem_write & rst_n;
    assign adr_src    = ctrl_q.adr_src;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign result_src = ctrl_q.result_src;
    assign flags      = flags_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed table, corner sequences, random instructions.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] op = 2'b00;
    logic [5:0] funct = 6'd0;
    logic [3:0] cond = 4'd0;
    logic       negative = 1'b0, zero = 1'b0, cout = 1'b0;
    logic       ir_write, pc_write, reg_write, mem_write, adr_src, alu_src_a, alu_op;
    logic [1:0] alu_src_b, result_src;
    logic [2:0] flags;
`ifdef ILLEGAL_TRAP_EN
    logic       halted;
`endif

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .cond(cond),
        .negative(negative), .zero(zero), .cout(cout),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .mem_write(mem_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
`ifdef ILLEGAL_TRAP_EN
        .halted(halted),
`endif
        .flags(flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // {ir, pc, rw, mw, adr, asa, asb[1:0], aluop, rs[1:0]}
    logic [10:0] vec;
    assign vec = {ir_write, pc_write, reg_write, mem_write, adr_src, alu_src_a,
                  alu_src_b, alu_op, result_src};

    localparam logic [10:0] V_FETCH  = 11'b1_1_0_0_0_1_10_0_10;
    localparam logic [10:0] V_DECODE = 11'b0_0_0_0_0_1_10_0_10;
    localparam logic [10:0] V_EXECR  = 11'b0_0_0_0_0_0_00_1_00;
    localparam logic [10:0] V_EXECI  = 11'b0_0_0_0_0_0_01_1_00;
    localparam logic [10:0] V_ALUWB  = 11'b0_0_0_0_0_0_00_0_00;
    localparam logic [10:0] V_MEMADR = 11'b0_0_0_0_0_0_01_0_00;
    localparam logic [10:0] V_MEMRD  = 11'b0_0_0_0_1_0_00_0_00;
    localparam logic [10:0] V_MEMWB  = 11'b0_0_0_0_0_0_00_0_01;
    localparam logic [10:0] V_MEMWR  = 11'b0_0_0_0_1_0_00_0_00;
    localparam logic [10:0] V_BRANCH = 11'b0_0_0_0_0_1_01_0_10;
    localparam logic [10:0] M_PC     = 11'b0_1_0_0_0_0_00_0_00;
    localparam logic [10:0] M_RW     = 11'b0_0_1_0_0_0_00_0_00;
    localparam logic [10:0] M_MW     = 11'b0_0_0_1_0_0_00_0_00;

    int checks = 0;
    int errors = 0;
    logic [2:0]  mflags;
    logic [10:0] expq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Condition pass from the architectural rules: pairs (Z, C, N), odd code inverts.
    function automatic bit model_pass(input logic [3:0] cd, input logic [2:0] f);
        logic [2:0] sel;
        if (cd == 4'd14) return 1'b1;
        if (cd > 4'd5) return 1'b0;
        sel = {f[2], f[0], f[1]};
        return sel[cd[2:1]] ^ cd[0];
    endfunction

    task automatic build(input logic [1:0] o, input logic [5:0] f, input bit p);
        expq.delete();
        expq.push_back(V_FETCH);
        expq.push_back(V_DECODE);
        case (o)
            2'b00: begin
                expq.push_back(f[5] ? V_EXECI : V_EXECR);
                expq.push_back(V_ALUWB | (p ? M_RW : 11'd0));
            end
            2'b01: begin
                expq.push_back(V_MEMADR);
                if (f[0]) begin
                    expq.push_back(V_MEMRD);
                    expq.push_back(V_MEMWB | (p ? M_RW : 11'd0));
                end else begin
                    expq.push_back(V_MEMWR | (p ? M_MW : 11'd0));
                end
            end
            2'b10: expq.push_back(V_BRANCH | (p ? M_PC : 11'd0));
            default: ;
        endcase
    endtask

    // Called with the DUT in FETCH; returns at the next FETCH.
    task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] cd,
                             input logic n, input logic z, input logic c,
                             input int exp_cyc, input int exp_flags);
        bit p;
        int cyc;
        p = model_pass(cd, mflags);
        build(o, f, p);
        op = o; funct = f; cond = cd; negative = n; zero = z; cout = c;
        cyc = 0;
        do begin
            chk("cycle_vec", vec, (cyc < expq.size()) ? expq[cyc] : 11'h7ff);
            @(negedge clk);
            cyc++;
        end while (!ir_write && cyc < 12);
        chk("cycle_count", cyc, expq.size());
        if (exp_cyc >= 0) chk("table_cycles", cyc, exp_cyc);
        if (o == 2'b00 && f[0] && p) mflags = {n, z, c};
        chk("flags", flags, mflags);
        if (exp_flags >= 0) chk("table_flags", flags, exp_flags);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] cond;
        logic       n, z, c;
        int         cyc;
        int         flg;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [1:0] ro;
        logic [3:0] rc;
        logic [3:0] good_conds [7];

        tbl.push_back('{2'b00, 6'b000001, 4'b1110, 1'b0, 1'b1, 1'b0, 4, 3'b010});
        tbl.push_back('{2'b10, 6'b000000, 4'b0000, 1'b1, 1'b0, 1'b1, 3, 3'b010});
        tbl.push_back('{2'b00, 6'b100001, 4'b1110, 1'b1, 1'b0, 1'b1, 4, 3'b101});
        tbl.push_back('{2'b10, 6'b000000, 4'b0000, 1'b0, 1'b1, 1'b0, 3, 3'b101});
        tbl.push_back('{2'b01, 6'b100001, 4'b1110, 1'b0, 1'b0, 1'b0, 5, 3'b101});
        tbl.push_back('{2'b01, 6'b100000, 4'b0011, 1'b0, 1'b0, 1'b1, 4, 3'b101});
        tbl.push_back('{2'b00, 6'b000001, 4'b0000, 1'b0, 1'b1, 1'b0, 4, 3'b101});
        tbl.push_back('{2'b00, 6'b000000, 4'b1110, 1'b0, 1'b1, 1'b1, 4, 3'b101});
        tbl.push_back('{2'b10, 6'b000000, 4'b0001, 1'b0, 1'b0, 1'b0, 3, 3'b101});
        tbl.push_back('{2'b01, 6'b000000, 4'b0100, 1'b0, 1'b0, 1'b0, 4, 3'b101});
`ifndef ILLEGAL_TRAP_EN
        tbl.push_back('{2'b11, 6'b000000, 4'b1110, 1'b0, 1'b0, 1'b0, 2, 3'b101});
`endif

        // Reset held for 3 cycles: no writes.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_writes", {ir_write, pc_write, reg_write, mem_write}, 4'b0000);
        end
        rst_n = 1'b1;
        #1;
        chk("post_reset_fetch", vec, V_FETCH);
        chk("post_reset_flags", flags, 3'b000);
`ifdef ILLEGAL_TRAP_EN
        chk("post_reset_halted", halted, 1'b0);
`endif
        mflags = 3'b000;

        foreach (tbl[i])
            run_instr(tbl[i].op, tbl[i].funct, tbl[i].cond, tbl[i].n, tbl[i].z, tbl[i].c,
                      tbl[i].cyc, tbl[i].flg);

        good_conds = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd14};
        for (int k = 0; k < 200; k++) begin
`ifdef ILLEGAL_TRAP_EN
            ro = 2'($urandom_range(0, 2));
`else
            ro = 2'($urandom_range(0, 3));
`endif
            rc = ($urandom_range(0, 3) != 0) ? good_conds[$urandom_range(0, 6)] : 4'($urandom);
            run_instr(ro, 6'($urandom), rc, 1'($urandom), 1'($urandom), 1'($urandom), -1, -1);
        end

        // Reset mid-instruction: abandon a store in MEMADR, flags cleared.
        run_instr(2'b00, 6'b000001, 4'b1110, 1'b1, 1'b0, 1'b1, 4, 3'b101);
        op = 2'b01; funct = 6'b000000; cond = 4'b1110;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_writes_now", {ir_write, pc_write, reg_write, mem_write}, 4'b0000);
        @(negedge clk);
        chk("midreset_writes_held", {ir_write, pc_write, reg_write, mem_write}, 4'b0000);
        rst_n = 1'b1;
        #1;
        chk("midreset_fetch", vec, V_FETCH);
        chk("midreset_flags", flags, 3'b000);
        mflags = 3'b000;
        run_instr(2'b01, 6'b000000, 4'b1110, 1'b0, 1'b0, 1'b0, 4, 3'b000);

`ifdef ILLEGAL_TRAP_EN
        // Illegal op traps into HALT until reset.
        op = 2'b11; funct = 6'd0; cond = 4'b1110;
        chk("ill_fetch", vec, V_FETCH);
        @(negedge clk);
        chk("ill_decode", vec, V_DECODE);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("halt_outputs", vec, 11'd0);
            chk("halt_flag", halted, 1'b1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("halt_cleared", halted, 1'b0);
        chk("halt_reset_fetch", vec, V_FETCH);
        mflags = 3'b000;
        run_instr(2'b10, 6'd0, 4'b1110, 1'b0, 1'b0, 1'b0, 3, 3'b000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control unit for the multicycle processor core. A Moore state machine steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath mux selects and write enables. It owns the architectural flag register (negative, zero, carry) and evaluates each instruction's 4-bit condition field against it. Every architectural write (register file, memory, PC on branch) is gated by the condition result.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 illegal
- funct  in  6  funct[5] = I (immediate operand); funct[0] = S (set flags) for data-processing, L (load) for memory
- cond  in  4  condition field from the instruction register
- negative  in  1  ALU negative flag
- zero  in  1  ALU zero flag
- cout  in  1  ALU carry-out
- ir_write  out  1  instruction register load
- pc_write  out  1  PC load
- reg_write  out  1  register file write
- mem_write  out  1  data memory write
- adr_src  out  1  memory address: 0 = PC, 1 = ALU result register
- alu_src_a  out  1  ALU A operand: 0 = register A, 1 = PC
- alu_src_b  out  2  ALU B operand: 00 = register B, 01 = extended immediate, 10 = constant 4
- alu_op  out  1  1 = ALU decodes funct; 0 = add
- result_src  out  2  result bus: 00 = ALU-out register, 01 = memory data register, 10 = ALU result direct
- flags  out  3  registered {negative, zero, cout}
- halted  out  1  illegal instruction seen; present only with the macro defined

## Operation
- Condition encoding, evaluated on registered flags:
  - 0000 zero; 0001 ~zero
  - 0010 cout; 0011 ~cout
  - 0100 negative; 0101 ~negative
  - 1110 always
  - all other codes never
- cond_pass register: captures the condition result on the edge that leaves DECODE. It holds until the next DECODE. All write gating uses cond_pass, so an instruction is evaluated on flags from before its own flag update.
- States, with outputs asserted in each (unlisted outputs are 0):
  - FETCH: ir_write=1, pc_write=1, adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10. Next: DECODE.
  - DECODE: alu_src_a=1, alu_src_b=10, result_src=10. Next state:
    - op=00, I=0 → EXECR
    - op=00, I=1 → EXECI
    - op=01 → MEMADR
    - op=10 → BRANCH
    - op=11 → see Configuration
  - EXECR: alu_src_b=00, alu_op=1. Next: ALUWB.
  - EXECI: alu_src_b=01, alu_op=1. Next: ALUWB.
  - ALUWB: result_src=00, reg_write=cond_pass. Next: FETCH.
  - MEMADR: alu_src_b=01. Next: MEMRD if L=1, else MEMWR.
  - MEMRD: adr_src=1. Next: MEMWB.
  - MEMWB: result_src=01, reg_write=cond_pass. Next: FETCH.
  - MEMWR: adr_src=1, mem_write=cond_pass. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=01, result_src=10, pc_write=cond_pass. Next: FETCH.
- Flag register: loads {negative, zero, cout} on the edge leaving EXECR or EXECI, only when S=1 and cond_pass=1. Otherwise it holds.
- A failed condition still walks through every state of the instruction; only the writes are suppressed.

## Timing
- Cycles per instruction: data-processing 4, load 5, store 4, branch 3.
- All outputs decode from registered state only, with no combinational path from ALU flags. Exception: in DECODE, next-state logic reads op and funct combinationally.
- op, funct and cond must be stable from DECODE until the instruction returns to FETCH; the instruction register guarantees this.
- Reset:
  - While rst_n=0: ir_write, pc_write, reg_write and mem_write are forced to 0.
  - On the edge with rst_n=0: state←FETCH, flags←000, cond_pass←0, halted←0.
  - The first fetch occurs in the first cycle with rst_n=1.
  - Reset asserted mid-instruction abandons that instruction; no further writes occur.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - op=11 in DECODE goes to HALT. HALT has all outputs 0, asserts halted=1, and is left only by reset.
- ILLEGAL_TRAP_EN undefined:
  - op=11 in DECODE returns to FETCH as a 2-cycle no-op.
  - The halted port and the HALT state do not exist.

## Structure
- Shared package ctrl_pkg holds:
  - state enum
  - op class constants
  - cond code constants
  - alu_src_b and result_src select constants
- One sub-module, cond_unit: combinational condition evaluator taking cond and the registered flags. It is instantiated once. The FSM, cond_pass and the flag register stay in the top module.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → all write enables 0 throughout. First cycle after release is in FETCH with ir_write=1, pc_write=1; flags=000.
- Register ADD with S=1, cond=1110, ALU zero=1 → states FETCH, DECODE, EXECR, ALUWB. reg_write=1 in ALUWB. flags=010 afterwards.
- EQ branch, cond=0000:
  - with flags zero=1 → pc_write=1 in BRANCH, 3 cycles total
  - with zero=0 → pc_write=0
- Load (op=01, L=1) → states MEMADR, MEMRD, MEMWB, 5 cycles total. adr_src=1 in MEMRD; result_src=01 and reg_write=1 in MEMWB.
- Store with cond=0011 and cout=1 → mem_write stays 0 in MEMWR; flags unchanged.
- op=11 →
  - with ILLEGAL_TRAP_EN: halted=1 persists until reset
  - without: FETCH follows after 2 cycles
